// File: rtl/yacht_pkg.sv
// Shared constants and FSM state type for the Yacht score engine.
package yacht_pkg;

  localparam int NUM_CAT = 12;

  localparam int CAT_ACES     = 0;
  localparam int CAT_TWOS     = 1;
  localparam int CAT_THREES   = 2;
  localparam int CAT_FOURS    = 3;
  localparam int CAT_FIVES    = 4;
  localparam int CAT_SIXES    = 5;
  localparam int CAT_CHOICE   = 6;
  localparam int CAT_FOUR_K   = 7;
  localparam int CAT_FULL_H   = 8;
  localparam int CAT_SM_STR   = 9;
  localparam int CAT_LG_STR   = 10;
  localparam int CAT_YACHT    = 11;

  localparam int FH_SCORE    = 25;
  localparam int SS_SCORE    = 30;
  localparam int LS_SCORE    = 40;
  localparam int YACHT_SCORE = 50;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_EVAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/yacht_score_engine_hist.sv
// Face histogram and pip-sum accumulator, one die per inc cycle.
// Out-of-range die values raise err and are neither counted nor summed.
module yacht_face_hist #(
  parameter int N_DICE  = 5,
  parameter int FACES   = 6,
  parameter int DIE_W   = $clog2(FACES + 1),
  parameter int SCORE_W = 8,
  parameter int CNT_W   = $clog2(N_DICE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [DIE_W-1:0]   die,
  output logic [CNT_W-1:0]   hist [FACES],
  output logic [SCORE_W-1:0] sum,
  output logic               err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FACES; f++) hist[f] <= '0;
      sum <= '0;
      err <= 1'b0;
    end else if (clr) begin
      for (int f = 0; f < FACES; f++) hist[f] <= '0;
      sum <= '0;
      err <= 1'b0;
    end else if (inc) begin
      if (die == '0 || die > DIE_W'(FACES)) begin
        err <= 1'b1;
      end else begin
        sum <= sum + SCORE_W'(die);
        // hist[f] counts face value f+1
        for (int f = 0; f < FACES; f++)
          if (die == DIE_W'(f + 1)) hist[f] <= hist[f] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/yacht_score_engine.sv
// Sequential Yacht scorer: histogram the hand, then score one category per
// cycle into a readable table while tracking the best unused category.
module yacht_score_engine #(
  parameter int N_DICE  = 5,
  parameter int FACES   = 6,
  parameter int DIE_W   = $clog2(FACES + 1),
  parameter int SCORE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_DICE*DIE_W-1:0] dice_in,
  input  logic [11:0]             used_mask,
  input  logic [3:0]              rd_cat,
  output logic [SCORE_W-1:0]      rd_score,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    best_valid,
  output logic [3:0]              best_cat,
  output logic [SCORE_W-1:0]      best_score
);
  import yacht_pkg::*;

  localparam int CNT_W = $clog2(N_DICE + 1);

  state_t                  state, state_nx;
  logic [3:0]              idx;
  logic [N_DICE*DIE_W-1:0] dice_q;
  logic [NUM_CAT-1:0]      used_q;
  logic [SCORE_W-1:0]      tbl  [NUM_CAT];
  logic [SCORE_W-1:0]      cand [NUM_CAT];
  logic [CNT_W-1:0]        hist [FACES];
  logic [SCORE_W-1:0]      sum;
  logic [SCORE_W-1:0]      score_cur;
  logic [DIE_W-1:0]        die_cur;
  logic                    accept, last_die, last_cat;
  logic                    any4, has3, has2, any_n, small_str, large_str;

  assign accept   = (state == ST_IDLE) && start;
  assign last_die = (idx == 4'(N_DICE - 1));
  assign last_cat = (idx == 4'(NUM_CAT - 1));
  assign die_cur  = dice_q[idx*DIE_W +: DIE_W];
  assign busy     = (state == ST_COUNT) || (state == ST_EVAL);
  assign done     = (state == ST_DONE);
  assign rd_score = (rd_cat < 4'(NUM_CAT)) ? tbl[rd_cat] : '0;

  yacht_face_hist #(
    .N_DICE (N_DICE),
    .FACES  (FACES),
    .DIE_W  (DIE_W),
    .SCORE_W(SCORE_W),
    .CNT_W  (CNT_W)
  ) u_hist (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (state == ST_COUNT),
    .die (die_cur),
    .hist(hist),
    .sum (sum),
    .err (err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start)    state_nx = ST_COUNT;
      ST_COUNT: if (last_die) state_nx = ST_EVAL;
      ST_EVAL:  if (last_cat) state_nx = ST_DONE;
      ST_DONE:                state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // idx walks dice during COUNT and categories during EVAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (state == ST_COUNT) begin
      idx <= last_die ? 4'd0 : idx + 4'd1;
    end else if (state == ST_EVAL) begin
      idx <= last_cat ? 4'd0 : idx + 4'd1;
    end
  end

  always_comb begin
    any4      = 1'b0;
    has3      = 1'b0;
    has2      = 1'b0;
    any_n     = 1'b0;
    small_str = 1'b0;
    large_str = 1'b0;
    for (int f = 0; f < FACES; f++) begin
      if (hist[f] >= CNT_W'(4))      any4  = 1'b1;
      if (hist[f] == CNT_W'(3))      has3  = 1'b1;
      if (hist[f] == CNT_W'(2))      has2  = 1'b1;
      if (hist[f] == CNT_W'(N_DICE)) any_n = 1'b1;
    end
    for (int s = 0; s <= FACES - 4; s++)
      if (hist[s] != '0 && hist[s+1] != '0 && hist[s+2] != '0 && hist[s+3] != '0)
        small_str = 1'b1;
    for (int s = 0; s <= FACES - 5; s++)
      if (hist[s] != '0 && hist[s+1] != '0 && hist[s+2] != '0 && hist[s+3] != '0 &&
          hist[s+4] != '0)
        large_str = 1'b1;
  end

  // has3 and has2 can never come from the same face, so together they mean a full house
  always_comb begin
    for (int c = 0; c < 6; c++) cand[c] = SCORE_W'(hist[c]) * SCORE_W'(c + 1);
    cand[CAT_CHOICE] = sum;
    cand[CAT_FOUR_K] = any4 ? sum : '0;
    cand[CAT_FULL_H] = ((has3 && has2) || any_n) ? SCORE_W'(FH_SCORE) : '0;
    cand[CAT_SM_STR] = small_str ? SCORE_W'(SS_SCORE) : '0;
    cand[CAT_LG_STR] = large_str ? SCORE_W'(LS_SCORE) : '0;
    cand[CAT_YACHT]  = any_n ? SCORE_W'(YACHT_SCORE) : '0;
    score_cur        = cand[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CAT; c++) tbl[c] <= '0;
      dice_q     <= '0;
      used_q     <= '0;
      best_valid <= 1'b0;
      best_cat   <= '0;
      best_score <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CAT; c++) tbl[c] <= '0;
      dice_q     <= dice_in;
      used_q     <= used_mask;
      best_valid <= 1'b0;
      best_cat   <= '0;
      best_score <= '0;
    end else if (state == ST_EVAL) begin
      tbl[idx] <= score_cur;
      // strict compare keeps the lowest-index category on ties
      if (!used_q[idx] && (!best_valid || score_cur > best_score)) begin
        best_valid <= 1'b1;
        best_cat   <= idx;
        best_score <= score_cur;
      end
    end
  end

endmodule

// File: tb/tb_yacht_score_engine.sv
// Directed bench for yacht_score_engine: default 5d6 instance plus a 7d8 instance.
module tb_yacht_score_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_b;
  logic [14:0] dice_s;
  logic [27:0] dice_b;
  logic [11:0] mask_s, mask_b;
  logic [3:0]  rd_cat;
  logic [7:0]  rd_score, rd_score_b, best_score, best_score_b;
  logic        busy, done, err, best_valid;
  logic        busy_b, done_b, err_b, best_valid_b;
  logic [3:0]  best_cat, best_cat_b;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int busy1, done_after, busy_after;

  always #5 clk = ~clk;

  yacht_score_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .dice_in(dice_s), .used_mask(mask_s),
    .rd_cat(rd_cat), .rd_score(rd_score), .busy(busy), .done(done), .err(err),
    .best_valid(best_valid), .best_cat(best_cat), .best_score(best_score)
  );

  yacht_score_engine #(.N_DICE(7), .FACES(8), .SCORE_W(8)) u_big (
    .clk(clk), .rst(rst), .start(start_b), .dice_in(dice_b), .used_mask(mask_b),
    .rd_cat(rd_cat), .rd_score(rd_score_b), .busy(busy_b), .done(done_b), .err(err_b),
    .best_valid(best_valid_b), .best_cat(best_cat_b), .best_score(best_score_b)
  );

  function automatic logic [27:0] p5(int a, int b, int c, int d, int e);
    return {13'd0, 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tbl(input string tag, input bit big, input int c, input int exp);
    rd_cat = 4'(c);
    #1;
    chk(tag, big ? int'(rd_score_b) : int'(rd_score), exp);
  endtask

  // lat = number of the cycle (after the accepting edge) in which done is seen
  task automatic run(input bit big, input logic [27:0] d, input logic [11:0] m, output int l);
    @(negedge clk);
    if (big) begin dice_b = d; mask_b = m; start_b = 1'b1; end
    else begin dice_s = d[14:0]; mask_s = m; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    busy1 = big ? busy_b : busy;
    l = 1;
    while (!(big ? done_b : done) && l < 60) begin
      @(negedge clk);
      l++;
    end
    @(negedge clk);
    done_after = big ? done_b : done;
    busy_after = big ? busy_b : busy;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0; rd_cat = '0;
    dice_s = '0; dice_b = '0; mask_s = '0; mask_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bv", best_valid, 0);
    chk("rst_bc", best_cat, 0);
    chk("rst_bs", best_score, 0);
    chk_tbl("rst_tbl0", 0, 0, 0);
    rst = 1'b0;

    run(0, p5(3, 3, 3, 5, 5), 12'h000, lat);
    chk("a_lat", lat, 18);
    chk("a_busy1", busy1, 1);
    chk("a_done_pulse", done_after, 0);
    chk("a_busy_after", busy_after, 0);
    chk_tbl("a_t2", 0, 2, 9);
    chk_tbl("a_t4", 0, 4, 10);
    chk_tbl("a_t6", 0, 6, 19);
    chk_tbl("a_t7", 0, 7, 0);
    chk_tbl("a_t8", 0, 8, 25);
    chk_tbl("a_t11", 0, 11, 0);
    chk("a_bc", best_cat, 8);
    chk("a_bs", best_score, 25);
    chk("a_err", err, 0);

    run(0, p5(6, 6, 6, 6, 6), 12'h800, lat);
    chk_tbl("b_t11", 0, 11, 50);
    chk_tbl("b_t8", 0, 8, 25);
    chk_tbl("b_t7", 0, 7, 30);
    chk_tbl("b_t5", 0, 5, 30);
    chk("b_bc", best_cat, 5);
    chk("b_bs", best_score, 30);
    chk("b_bv", best_valid, 1);

    run(0, p5(1, 2, 3, 4, 6), 12'h000, lat);
    chk_tbl("c_t9", 0, 9, 30);
    chk_tbl("c_t10", 0, 10, 0);
    chk_tbl("c_rd12", 0, 12, 0);
    chk_tbl("c_rd15", 0, 15, 0);

    run(0, p5(2, 3, 4, 5, 6), 12'h000, lat);
    chk_tbl("d_t9", 0, 9, 30);
    chk_tbl("d_t10", 0, 10, 40);
    chk_tbl("d_t6", 0, 6, 20);
    chk("d_bc", best_cat, 10);
    chk("d_bs", best_score, 40);

    run(0, p5(7, 1, 1, 1, 1), 12'hFFF, lat);
    chk("e_err", err, 1);
    chk_tbl("e_t0", 0, 0, 4);
    chk_tbl("e_t7", 0, 7, 4);
    chk_tbl("e_t6", 0, 6, 4);
    chk_tbl("e_t11", 0, 11, 0);
    chk("e_bv", best_valid, 0);
    chk("e_bc", best_cat, 0);
    chk("e_bs", best_score, 0);

    // start while busy and while in DONE must be ignored
    @(negedge clk);
    dice_s = p5(1, 1, 1, 1, 1)[14:0]; mask_s = 12'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    dice_s = p5(2, 2, 2, 2, 2)[14:0]; start = 1'b1;
    @(negedge clk);
    lat++; start = 1'b0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    chk("f_lat", lat, 18);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f_done_start_busy", busy, 0);
    @(negedge clk);
    chk("f_idle_busy", busy, 0);
    chk_tbl("f_t0", 0, 0, 5);
    chk_tbl("f_t1", 0, 1, 0);
    chk_tbl("f_t11", 0, 11, 50);

    // reset while in EVAL
    @(negedge clk);
    dice_s = p5(7, 1, 1, 1, 1)[14:0]; mask_s = 12'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    chk("g_pre_busy", busy, 1);
    chk("g_pre_err", err, 1);
    chk("g_pre_bv", best_valid, 1);
    rst = 1'b1;
    #1;
    chk("g_busy", busy, 0);
    chk("g_done", done, 0);
    chk("g_err", err, 0);
    chk("g_bv", best_valid, 0);
    chk("g_bc", best_cat, 0);
    chk("g_bs", best_score, 0);
    chk_tbl("g_t0", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, p5(3, 3, 3, 5, 5), 12'h000, lat);
    chk("h_lat", lat, 18);
    chk("h_bc", best_cat, 8);
    chk_tbl("h_t6", 0, 6, 19);

    run(1, 28'h8888888, 12'h040, lat);
    chk("i_lat", lat, 20);
    chk_tbl("i_t7", 1, 7, 56);
    chk_tbl("i_t6", 1, 6, 56);
    chk_tbl("i_t8", 1, 8, 25);
    chk_tbl("i_t11", 1, 11, 50);
    chk_tbl("i_t5", 1, 5, 0);
    chk("i_bc", best_cat_b, 7);
    chk("i_bs", best_score_b, 56);
    chk("i_err", err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
